dev_timer: RTL and testbench

Memory-mapped timer peripheral. It is the responder on the CPU data bus (address, write data, byte enables, read data) and the source of one HWInt line back into the core. It decodes a 16-byte window and exposes three registers: CTRL, PRESET and COUNT. It counts down from PRESET and raises an interrupt request on terminal count, in either one-shot or auto-reload mode.

---
 rtl/dev_defs.sv | 39 +++
 rtl/be_merge.sv | 22 ++
 rtl/dev_timer.sv | 145 ++++++++++++++
 tb/tb_dev_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_defs.sv
// Shared definitions for the memory-mapped timer: register offsets, FSM states, CTRL layout.
// Pure declarations, no logic; imported by the timer and bus-facing device models.
// No flow control; constants and types only.
package dev_defs;

    localparam logic [1:0] TIM_CTRL   = 2'd0;
    localparam logic [1:0] TIM_PRESET = 2'd1;
    localparam logic [1:0] TIM_COUNT  = 2'd2;
    localparam logic [1:0] TIM_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tim_state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    // Field order matches the bit positions above: im=[3], mode=[2:1], en=[0].
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // Mode codes 1x fall back to one-shot, so only the exact reload code reloads.
    function automatic logic is_reload(input ctrl_t c);
        return c.mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/be_merge.sv
// Byte-lane merge: each lane takes wdata when its strobe is set, otherwise keeps old_dat.
// Purely combinational, zero latency.
// No flow control; the caller decides when the merged value is committed.
module be_merge #(
    parameter int W = 32
) (
    input  logic [W-1:0]   old_dat,
    input  logic [W-1:0]   wdata,
    input  logic [W/8-1:0] byteen,
    output logic [W-1:0]   new_dat
);

    always_comb begin
        new_dat = old_dat;
        for (int i = 0; i < W / 8; i++) begin
            if (byteen[i]) begin
                new_dat[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dev_timer.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a maskable irq.
// Reads are combinational from addr; writes commit on the clock edge; irq is first high PRESET+3 edges after EN is set.
// Never stalls the bus: every access completes in the cycle it is presented.
module dev_timer
    import dev_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          COUNT_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    tim_state_e          state;
    ctrl_t               ctrl;
    logic [COUNT_W-1:0]  preset;
    logic [COUNT_W-1:0]  count;
    logic                pending;

    logic                hit;
    logic [1:0]          offset;
    logic                wr_en;
    logic                wr_ctrl;
    logic                wr_preset;

    ctrl_t               ctrl_hw;
    logic [31:0]         ctrl_merged;
    logic [COUNT_W-1:0]  preset_merged;
    logic                term_evt;
    logic                pend_clr;

    logic                unused_addr_lsb;
    logic                unused_ctrl_hi;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = addr[3:2];
    assign wr_en     = hit && (byteen != 4'b0000);
    assign wr_ctrl   = wr_en && (offset == TIM_CTRL);
    assign wr_preset = wr_en && (offset == TIM_PRESET);

    assign unused_addr_lsb = ^addr[1:0];
    assign unused_ctrl_hi  = ^ctrl_merged[31:CTRL_W];

    // Hardware EN clear is applied first; CPU bytes merged on top override it.
    always_comb begin
        ctrl_hw = ctrl;
        if (state == INT && !is_reload(ctrl)) begin
            ctrl_hw.en = 1'b0;
        end
    end

    be_merge #(.W(32)) u_ctrl_merge (
        .old_dat ({{(32 - CTRL_W){1'b0}}, ctrl_hw}),
        .wdata   (wdata),
        .byteen  (byteen),
        .new_dat (ctrl_merged)
    );

    be_merge #(.W(COUNT_W)) u_preset_merge (
        .old_dat (preset),
        .wdata   (wdata[COUNT_W-1:0]),
        .byteen  (byteen[COUNT_W/8-1:0]),
        .new_dat (preset_merged)
    );

    assign term_evt = (state == CNT) && ctrl.en && (count == '0);
    assign pend_clr = wr_ctrl || wr_preset || (state == INT && is_reload(ctrl));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= ctrl_t'(ctrl_merged[CTRL_W-1:0]);
            end else begin
                ctrl <= ctrl_hw;
            end

            if (wr_preset) begin
                preset <= preset_merged;
            end

            // Terminal-count event beats a same-edge software clear.
            if (term_evt) begin
                pending <= 1'b1;
            end else if (pend_clr) begin
                pending <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (ctrl.en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl.en) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        state <= INT;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                INT: begin
                    if (is_reload(ctrl)) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            unique case (offset)
                TIM_CTRL:   rdata = {{(32 - CTRL_W){1'b0}}, ctrl};
                TIM_PRESET: rdata = 32'(preset);
                TIM_COUNT:  rdata = 32'(count);
                TIM_RSVD:   rdata = 32'h0;
            endcase
        end
    end

    assign irq = pending && ctrl.im;

endmodule

// File: tb/tb_dev_timer.sv
// Directed bench for dev_timer: reset, byte enables, one-shot, auto-reload, pause and coincident events.
module tb_dev_timer;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;
    localparam logic [31:0] A_OUT    = 32'h0000_7F10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] rd_addrs [5];

    dev_timer #(
        .BASE_ADDR (32'h0000_7F00),
        .COUNT_W   (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Drive at a negedge, commit on the following posedge, return at the next negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        @(negedge clk);
        byteen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        idle(3);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd4) begin miscompares++; $display("FAIL pre_reset_count got=%h want=%h", v, 32'd4); end
        #1;
        reset = 1'b0;
        #1;
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL async_reset_count got=%h want=%h", v, 32'd0); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL async_reset_irq got=%b want=0", irq); end
        rd(A_CTRL, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL async_reset_ctrl got=%h want=%h", v, 32'd0); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd(rd_addrs[i], v);
            vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_read[%0d] got=%h want=%h", i, v, 32'd0); end
            vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq[%0d] got=%b want=0", i, irq); end
        end
    endtask

    task automatic test_byteen();
        logic [31:0] v;
        wr(A_PRESET, 32'h1122_3344, 4'hF);
        rd(A_PRESET, v);
        vectors++; if (v !== 32'h1122_3344) begin miscompares++; $display("FAIL preset_full got=%h want=%h", v, 32'h1122_3344); end
        wr(A_PRESET, 32'hAABB_CCDD, 4'b0101);
        rd(A_PRESET, v);
        vectors++; if (v !== 32'h11BB_33DD) begin miscompares++; $display("FAIL preset_lanes got=%h want=%h", v, 32'h11BB_33DD); end
        wr(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL count_ro got=%h want=%h", v, 32'd0); end
        wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        rd(A_RSVD, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL rsvd_read got=%h want=%h", v, 32'd0); end
        wr(32'h0000_7F14, 32'hDEAD_BEEF, 4'hF);
        rd(A_PRESET, v);
        vectors++; if (v !== 32'h11BB_33DD) begin miscompares++; $display("FAIL out_of_window_wr got=%h want=%h", v, 32'h11BB_33DD); end
        wr(A_CTRL, 32'hFFFF_FFF0, 4'hF);
        rd(A_CTRL, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL ctrl_upper_bits got=%h want=%h", v, 32'd0); end
        wr(A_CTRL, 32'h0000_0006, 4'b0001);
        rd(A_CTRL, v);
        vectors++; if (v !== 32'h6) begin miscompares++; $display("FAIL ctrl_mode_store got=%h want=%h", v, 32'h6); end
        wr(A_CTRL, 32'hFFFF_FFFF, 4'b1110);
        rd(A_CTRL, v);
        vectors++; if (v !== 32'h6) begin miscompares++; $display("FAIL ctrl_lane0_kept got=%h want=%h", v, 32'h6); end
        wr(A_CTRL, 32'h0, 4'hF);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL byteen_irq got=%b want=0", irq); end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        logic [31:0] exp_c;
        logic        exp_i;
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            rd(A_COUNT, v);
            exp_c = (k < 2) ? 32'd0 : ((k <= 7) ? 32'(7 - k) : 32'd0);
            exp_i = (k >= 8);
            vectors++; if (v !== exp_c) begin miscompares++; $display("FAIL oneshot_count[%0d] got=%h want=%h", k, v, exp_c); end
            vectors++; if (irq !== exp_i) begin miscompares++; $display("FAIL oneshot_irq[%0d] got=%b want=%b", k, irq, exp_i); end
        end
        rd(A_CTRL, v);
        vectors++; if (v !== 32'h8) begin miscompares++; $display("FAIL oneshot_ctrl_en_clr got=%h want=%h", v, 32'h8); end
        wr(A_CTRL, 32'h8, 4'hF);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_irq_clr got=%b want=0", irq); end
    endtask

    task automatic run_reload(input logic [31:0] ctrl_val, input logic [31:0] start_c, input logic masked);
        logic [31:0] v;
        logic [31:0] exp_c;
        logic        exp_i;
        wr(A_CTRL, ctrl_val, 4'hF);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            rd(A_COUNT, v);
            if (k < 2) exp_c = start_c;
            else if ((k - 2) % 5 == 0) exp_c = 32'd2;
            else if ((k - 2) % 5 == 1) exp_c = 32'd1;
            else exp_c = 32'd0;
            exp_i = !masked && (k >= 5) && ((k - 5) % 5 == 0);
            vectors++; if (v !== exp_c) begin miscompares++; $display("FAIL reload_count[m%0d,%0d] got=%h want=%h", masked, k, v, exp_c); end
            vectors++; if (irq !== exp_i) begin miscompares++; $display("FAIL reload_irq[m%0d,%0d] got=%b want=%b", masked, k, irq, exp_i); end
        end
        // Stop lands in LOAD, so COUNT freezes at PRESET.
        wr(A_CTRL, 32'h0, 4'hF);
        idle(3);
    endtask

    task automatic test_reload();
        logic [31:0] v;
        wr(A_PRESET, 32'd2, 4'hF);
        run_reload(32'hB, 32'd0, 1'b0);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd2) begin miscompares++; $display("FAIL reload_stop_count got=%h want=%h", v, 32'd2); end
        run_reload(32'h3, 32'd2, 1'b1);
    endtask

    task automatic test_edges();
        logic [31:0] v;
        logic [31:0] exp_c;
        logic        exp_i;
        // Pause at COUNT = 3, then restart from PRESET.
        wr(A_PRESET, 32'd6, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        idle(4);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd4) begin miscompares++; $display("FAIL pause_pre got=%h want=%h", v, 32'd4); end
        wr(A_CTRL, 32'h0, 4'hF);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd3) begin miscompares++; $display("FAIL pause_at3 got=%h want=%h", v, 32'd3); end
        idle(3);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd3) begin miscompares++; $display("FAIL pause_hold got=%h want=%h", v, 32'd3); end
        wr(A_CTRL, 32'h1, 4'hF);
        idle(2);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd6) begin miscompares++; $display("FAIL restart_reload got=%h want=%h", v, 32'd6); end
        wr(A_PRESET, 32'd20, 4'hF);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd5) begin miscompares++; $display("FAIL preset_midrun got=%h want=%h", v, 32'd5); end
        idle(1);
        rd(A_COUNT, v);
        vectors++; if (v !== 32'd4) begin miscompares++; $display("FAIL preset_midrun2 got=%h want=%h", v, 32'd4); end
        rd(A_PRESET, v);
        vectors++; if (v !== 32'd20) begin miscompares++; $display("FAIL preset_midrun_val got=%h want=%h", v, 32'd20); end
        wr(A_CTRL, 32'h0, 4'hF);
        idle(2);

        // PRESET = 0 with mode 2'b10 (behaves as one-shot).
        wr(A_PRESET, 32'd0, 4'hF);
        wr(A_CTRL, 32'hD, 4'hF);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            rd(A_COUNT, v);
            exp_c = (k < 2) ? 32'd3 : 32'd0;
            exp_i = (k >= 3);
            vectors++; if (v !== exp_c) begin miscompares++; $display("FAIL zero_preset_count[%0d] got=%h want=%h", k, v, exp_c); end
            vectors++; if (irq !== exp_i) begin miscompares++; $display("FAIL zero_preset_irq[%0d] got=%b want=%b", k, irq, exp_i); end
        end
        rd(A_CTRL, v);
        vectors++; if (v !== 32'hC) begin miscompares++; $display("FAIL mode10_oneshot got=%h want=%h", v, 32'hC); end
        wr(A_CTRL, 32'h0, 4'hF);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL zero_preset_clr got=%b want=0", irq); end

        // CTRL write on the CNT->INT edge, then on the INT hardware-clear edge.
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        idle(4);
        wr(A_CTRL, 32'h9, 4'hF);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL coincident_term_irq got=%b want=1", irq); end
        wr(A_CTRL, 32'h9, 4'hF);
        rd(A_CTRL, v);
        vectors++; if (v !== 32'h9) begin miscompares++; $display("FAIL cpu_wins_en_clr got=%h want=%h", v, 32'h9); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL int_edge_write_clr got=%b want=0", irq); end
        wr(A_CTRL, 32'h0, 4'hF);
        idle(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        rd_addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD, A_OUT};
        reset  = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        byteen = 4'h0;
        idle(2);
        reset = 1'b1;
        idle(1);
        test_reset();
        test_byteen();
        test_oneshot();
        test_reload();
        test_edges();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
